// File: rtl/mod_alu_pkg.sv
// mod_alu_pkg: shared FSM encoding, default width and modular helpers for the mod ALU stages
package mod_alu_pkg;
  localparam int W_DEF = 32;
  localparam int MAXW = 64;
  typedef enum logic [2:0] {IDLE = 3'd0, REDUCE = 3'd1, CHECK = 3'd2, EUCLID = 3'd3, DONE = 3'd4} state_t;
  // (p - q) mod m for p, q in [0, m-1]; the carry bit keeps p + m from wrapping at full width
  function automatic logic [MAXW-1:0] submod(input logic [MAXW-1:0] p, input logic [MAXW-1:0] q,
                                             input logic [MAXW-1:0] m);
    return (p >= q) ? p - q : MAXW'({1'b0, p} + {1'b0, m} - {1'b0, q});
  endfunction
endpackage

// File: rtl/mod_reduce_seq.sv
// mod_reduce_seq: bit-serial restoring reduction rem = b mod m, one quotient bit per cycle MSB first
module mod_reduce_seq import mod_alu_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] rem
);
  localparam int CW = $clog2(W);
  logic [W-1:0] m_r, b_r;
  logic [CW-1:0] cnt;
  logic [W:0] t;
  assign t = {rem, b_r[cnt]};
  assign done = busy && cnt == '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt <= '0;
      m_r <= '0;
      b_r <= '0;
      rem <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= CW'(W - 1);
      m_r <= m;
      b_r <= b;
      rem <= '0;
    end else if (busy) begin
      rem <= W'((t >= {1'b0, m_r}) ? t - {1'b0, m_r} : t);
      cnt <= cnt - CW'(1);
      busy <= cnt != '0;
    end
  end
endmodule

// File: rtl/mod_inv_seq.sv
// mod_inv_seq: modular inverse b^-1 mod m via pre-reduction then subtractive extended Euclid
module mod_inv_seq import mod_alu_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] inv,
  output logic         err
);
  state_t state, state_n;
  logic [W-1:0] m_r, u, v, x1, x2, rem, sm1, sm2;
  logic rd_busy, rd_done, accept, bad;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign accept = in_valid & in_ready;
  assign bad = m_r < W'(2) || rem == '0;
  assign sm1 = W'(submod(MAXW'(x1), MAXW'(x2), MAXW'(m_r)));
  assign sm2 = W'(submod(MAXW'(x2), MAXW'(x1), MAXW'(m_r)));
  mod_reduce_seq #(.W(W)) u_reduce (
    .clk(clk), .rst_n(rst_n), .start(accept), .b(b), .m(m),
    .busy(rd_busy), .done(rd_done), .rem(rem)
  );
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = in_valid ? REDUCE : IDLE;
      REDUCE:  state_n = (rd_busy & rd_done) ? CHECK : REDUCE;
      CHECK:   state_n = bad ? DONE : EUCLID;
      EUCLID:  state_n = (u == v) ? DONE : EUCLID;
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      m_r <= '0;
      u <= '0;
      v <= '0;
      x1 <= '0;
      x2 <= '0;
      inv <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) m_r <= m;
      if (state == CHECK) begin
        if (bad) begin
          inv <= '0;
          err <= 1'b1;
        end else begin
          u <= rem;
          x1 <= W'(1);
          v <= m_r;
          x2 <= '0;
        end
      end
      // u and v stay positive, so equality is the gcd and ends the walk
      if (state == EUCLID) begin
        if (u == v) begin
          inv <= (u == W'(1)) ? x1 : '0;
          err <= u != W'(1);
        end else if (u > v) begin
          u <= u - v;
          x1 <= sm1;
        end else begin
          v <= v - u;
          x2 <= sm2;
        end
      end
    end
  end
endmodule

// File: tb/tb_mod_inv_seq.sv
// tb_mod_inv_seq: directed W=8 vectors plus randomized W=32 back-to-back jobs against an extended-Euclid model
module tb_mod_inv_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic iv8, ir8, ov8, or8, err8;
  logic [7:0] b8, m8, inv8;
  logic iv32, ir32, ov32, or32, err32;
  logic [31:0] b32, m32, inv32;

  mod_inv_seq #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .b(b8), .m(m8),
    .out_valid(ov8), .out_ready(or8), .inv(inv8), .err(err8)
  );
  mod_inv_seq #(.W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .b(b32), .m(m32),
    .out_valid(ov32), .out_ready(or32), .inv(inv32), .err(err32)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Division-based extended Euclid; qs = sum of partial quotients bounds the engine's step count
  task automatic ref_model(input longint unsigned bb, input longint unsigned mm,
                           output longint unsigned ri, output bit re, output longint unsigned qs);
    longint r0, r1, t0, t1, q, tmp, sm;
    qs = 0;
    ri = 0;
    re = 1'b1;
    if (mm >= 2) begin
      sm = longint'(mm);
      r0 = sm;
      r1 = longint'(bb % mm);
      t0 = 0;
      t1 = 1;
      while (r1 != 0) begin
        q = r0 / r1;
        qs += longint'(q);
        tmp = r0 - q * r1; r0 = r1; r1 = tmp;
        tmp = t0 - q * t1; t0 = t1; t1 = tmp;
      end
      re = r0 != 1;
      ri = re ? 0 : longint'(((t0 % sm) + sm) % sm);
    end
  endtask

  task automatic wait8(output int lat);
    lat = 0;
    while (!ov8 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ov8) chk("timeout8", 0, 1);
  endtask

  task automatic job8(input logic [7:0] bb, input logic [7:0] mm, output int lat);
    int l;
    @(negedge clk);
    b8 = bb; m8 = mm; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    wait8(l);
    lat = l;
  endtask

  task automatic rel8;
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  typedef struct {logic [7:0] b, m, inv; logic err; int lat;} vec_t;
  vec_t tbl[$];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat, t;
    longint unsigned ri, qs, bb, mm, cb, cm;
    bit re;
    tbl.push_back('{8'd3, 8'd7, 8'd5, 1'b0, 14});
    tbl.push_back('{8'd200, 8'd13, 8'd8, 1'b0, -1});
    tbl.push_back('{8'd4, 8'd8, 8'd0, 1'b1, 11});
    tbl.push_back('{8'd0, 8'd11, 8'd0, 1'b1, 9});
    tbl.push_back('{8'd5, 8'd1, 8'd0, 1'b1, 9});
    tbl.push_back('{8'd5, 8'd0, 8'd0, 1'b1, 9});
    tbl.push_back('{8'd1, 8'd255, 8'd1, 1'b0, 264});
    tbl.push_back('{8'd254, 8'd255, 8'd254, 1'b0, -1});
    tbl.push_back('{8'd255, 8'd255, 8'd0, 1'b1, 9});
    tbl.push_back('{8'd2, 8'd3, 8'd2, 1'b0, -1});
    iv8 = 0; or8 = 0; b8 = 0; m8 = 0;
    iv32 = 0; or32 = 1; b32 = 0; m32 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", ir8, 1);
    chk("rst_out_valid", ov8, 0);
    chk("rst_inv", inv8, 0);
    chk("rst_err", err8, 0);
    chk("rst_in_ready32", ir32, 1);
    chk("rst_out_valid32", ov32, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      job8(tbl[i].b, tbl[i].m, lat);
      chk($sformatf("vec%0d_inv", i), inv8, tbl[i].inv);
      chk($sformatf("vec%0d_err", i), err8, tbl[i].err);
      if (tbl[i].lat >= 0) chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      rel8;
    end

    // result held while the consumer stalls; a pending request waits for release
    job8(8'd3, 8'd7, lat);
    iv8 = 1'b1; b8 = 8'd2; m8 = 8'd7;
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold_out_valid", ov8, 1);
      chk("hold_inv", inv8, 5);
      chk("hold_err", err8, 0);
      chk("hold_in_ready", ir8, 0);
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    chk("release_out_valid", ov8, 0);
    chk("release_in_ready", ir8, 1);
    @(posedge clk); #1;
    iv8 = 1'b0;
    chk("next_accept_in_ready", ir8, 0);
    wait8(lat);
    chk("next_inv", inv8, 4);
    chk("next_err", err8, 0);
    rel8;

    // reset in the middle of a long EUCLID walk
    @(negedge clk);
    b8 = 8'd1; m8 = 8'd251; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midrun_busy", ov8, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", ir8, 1);
    chk("midrst_out_valid", ov8, 0);
    chk("midrst_inv", inv8, 0);
    chk("midrst_err", err8, 0);
    job8(8'd2, 8'd251, lat);
    chk("after_rst_inv", inv8, 126);
    chk("after_rst_err", err8, 0);
    rel8;

    // W=32 random jobs, in_valid held high, out_ready always high
    bb = 0; mm = 0;
    for (int i = 0; i <= 40; i++) begin
      if (i > 0) begin
        cb = bb; cm = mm;
      end
      if (i < 40) begin
        do begin
          mm = (i % 4 == 0) ? longint'($urandom_range(3, 999) | 1) : longint'($urandom | 1);
          if (i == 5 || i == 17) mm = 64'hFFFF_FFFF;
          bb = (i == 9) ? 0 : (i == 13) ? mm * 3 : longint'($urandom);
          bb = bb & 64'hFFFF_FFFF;
          ref_model(bb, mm, ri, re, qs);
        end while (qs > 500);
      end
      if (i > 0) begin
        t = 0;
        while (!ov32 && t < 700) begin
          @(posedge clk); #1;
          t++;
        end
        if (!ov32) chk("timeout32", 0, 1);
        ref_model(cb, cm, ri, re, qs);
        chk($sformatf("rand%0d_inv", i), inv32, ri);
        chk($sformatf("rand%0d_err", i), err32, re);
        if (!re) chk($sformatf("rand%0d_prod", i), (64'(inv32) * (cb % cm)) % cm, 1);
      end
      if (i < 40) begin
        @(negedge clk);
        t = 0;
        while (!ir32 && t < 10) begin
          @(negedge clk);
          t++;
        end
        if (!ir32) chk("ready32", 0, 1);
        b32 = 32'(bb); m32 = 32'(mm); iv32 = 1'b1;
        @(posedge clk); #1;
        chk("accept32", ir32, 0);
      end else iv32 = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
